multi_issue_queue: RTL and testbench
====================================

# multi_issue_queue

Parametrised N-in/M-out in-order instruction queue between `decoder` and `dispatch` in the backend. It generalises the fixed two-wide decode-to-dispatch handoff to `ENQ_WIDTH` producers and `DEQ_WIDTH` consumers over a circular buffer of `DEPTH` entries. It provides all-or-nothing enqueue backpressure, prefix-ordered partial dequeue, pipeline pause and single-cycle flush.

## Interface
Parameters:
- `DATA_WIDTH`, default 128: width of one queued entry (packed `id_dispatch_t`-sized payload).
- `DEPTH`, default 16: number of entries. Must be a power of two and at least `ENQ_WIDTH+DEQ_WIDTH`.
- `ENQ_WIDTH`, default 2: enqueue lanes per cycle.
- `DEQ_WIDTH`, default 2: dequeue lanes per cycle.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `flush`  in  1: discard all contents.
- `pause`  in  1: freeze dequeue side.
- `enq_valid`  in  `ENQ_WIDTH`: per-lane write request.
- `enq_data`  in  `ENQ_WIDTH`×`DATA_WIDTH`: lane payloads.
- `enq_ready`  out  1: queue can accept a full `ENQ_WIDTH` group this cycle.
- `deq_valid`  out  `DEQ_WIDTH`: head entries present.
- `deq_data`  out  `DEQ_WIDTH`×`DATA_WIDTH`: head payloads; lane 0 is the oldest entry.
- `deq_en`  in  `DEQ_WIDTH`: consumer takes lane.
- `count`  out  `$clog2(DEPTH)+1`: current occupancy.

## Operation
- State: `head`, `tail` (`$clog2(DEPTH)` bits each, wrap modulo `DEPTH`), `count`, storage array. Storage is not reset.
- Enqueue effective lanes = longest prefix of `enq_valid` starting at lane 0. A lane after the first 0 is ignored.
- Enqueue occurs only when `enq_ready`=1 and `flush`=0. The k effective lanes are written to `tail..tail+k-1` in lane order, and `tail` advances by k.
- `enq_ready` = (`DEPTH`−`count` ≥ `ENQ_WIDTH`). It is computed from the registered `count` only; a same-cycle dequeue does not raise it.
- `deq_valid[i]` = (`count` > i). `deq_data[i]` = storage[`head`+i]. `deq_data[i]` is forced to 0 when `deq_valid[i]`=0.
- Dequeue effective lanes = longest prefix of (`deq_en` & `deq_valid`). `head` advances by that number j.
- `pause`=1: dequeue is disabled (j=0) and `deq_en` is ignored. Enqueue proceeds normally.
- `count_next` = `count` + k − j.
- `flush`=1: `head`, `tail` and `count` go to 0 next cycle. Enqueue and dequeue in that cycle are both suppressed. `flush` overrides `pause`.
- Arithmetic: pointer sums wrap modulo `DEPTH`. `count` never exceeds `DEPTH`, which is guaranteed by the `enq_ready` rule.

## Timing
- Reset (`rst`=0, asynchronous): `head`=`tail`=`count`=0, so `deq_valid`=0, `deq_data`=0 and `enq_ready`=1. This holds immediately and during reset. Release is sampled at the next `clk` edge.
- Enqueue-to-visible latency is 1 cycle. An entry written at edge n appears on `deq_valid` and `deq_data` after edge n.
- `deq_valid`, `deq_data`, `enq_ready` and `count` are functions of registered state only, with no combinational path from `enq_*` or `deq_en`. `deq_data` is a mux from registered storage.
- Full (`count`=`DEPTH`): `enq_ready`=0, and any `enq_valid` is dropped. The producer must hold it.
- Empty: `deq_valid`=0, and `deq_en` is ignored.
- Simultaneous enqueue and dequeue at `count`=`DEPTH`−`ENQ_WIDTH`: enqueue is allowed, and the new `count` = `DEPTH`−j.
- Wrap: a group straddling index `DEPTH`−1→0 is written and read contiguously in lane order.
- Reset asserted mid-stream clears everything at once, with no partial writes retained.

## Test plan
- Reset and basic: hold `rst`=0 for 3 cycles, then release. Expect `enq_ready`=1, `deq_valid`=00, `count`=0. Enqueue {A,B} with `enq_valid`=11. Next cycle expect `deq_valid`=11, `deq_data`={A,B}, `count`=2.
- Fill and backpressure: defaults, no dequeue, 8 consecutive enqueues of 2. Expect `count`=16 and `enq_ready`=0. A further enqueue attempt leaves `count`=16 and contents unchanged.
- Partial and non-prefix: 3 entries {X,Y,Z} queued. Apply `deq_en`=01, then expect `deq_data[0]`=Y. Apply `deq_en`=10 (non-prefix), then expect nothing consumed and `count`=2. Apply `enq_valid`=10, then expect nothing enqueued.
- Wrap-around: cycle 30 entries through the queue with simultaneous 2-in/2-out. Expect output order identical to input order and `count` steady at its initial value.
- Pause and flush: 4 entries queued, `pause`=1, `deq_en`=11, enqueue 2. Expect `count`=6. Then `flush`=1 together with enqueue and `deq_en`. Next cycle expect `count`=0 and `deq_valid`=00.
- Async reset mid-operation: with `count`=10, drop `rst` between clock edges. Expect `count`=0 and `deq_valid`=00 before the next edge.

Source files
------------

// File: rtl/multi_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : multi_issue_queue
// Description : In-order N-in/M-out circular instruction queue between decode
//               and dispatch; all-or-nothing enqueue, prefix partial dequeue,
//               pause and single-cycle flush.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_issue_queue #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 16,
    parameter int ENQ_WIDTH  = 2,
    parameter int DEQ_WIDTH  = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            pause,
    input  logic [ENQ_WIDTH-1:0]            enq_valid,
    input  logic [ENQ_WIDTH*DATA_WIDTH-1:0] enq_data,
    output logic                            enq_ready,
    output logic [DEQ_WIDTH-1:0]            deq_valid,
    output logic [DEQ_WIDTH*DATA_WIDTH-1:0] deq_data,
    input  logic [DEQ_WIDTH-1:0]            deq_en,
    output logic [$clog2(DEPTH):0]          count
);

    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam int                 c_CNT_W     = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_ENQ_LIMIT = c_CNT_W'(DEPTH - ENQ_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_head;
    logic [c_PTR_W-1:0]    r_tail;
    logic [c_CNT_W-1:0]    r_count;

    logic                  w_enq_ok;
    logic                  w_deq_ok;
    logic                  w_enq_run;
    logic                  w_deq_run;
    logic [ENQ_WIDTH-1:0]  w_enq_mask;
    logic [DEQ_WIDTH-1:0]  w_deq_take;
    logic [DEQ_WIDTH-1:0]  w_deq_valid;
    logic [c_CNT_W-1:0]    w_enq_k;
    logic [c_CNT_W-1:0]    w_deq_j;

    assign enq_ready = (r_count <= c_ENQ_LIMIT);
    assign w_enq_ok  = enq_ready && !flush;
    assign w_deq_ok  = !pause && !flush;
    assign deq_valid = w_deq_valid;
    assign count     = r_count;

    // Only the unbroken run of requests starting at lane 0 counts on either side.
    always_comb begin
        w_enq_run  = 1'b1;
        w_enq_mask = '0;
        w_enq_k    = '0;
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            if (w_enq_run && enq_valid[i] && w_enq_ok) begin
                w_enq_mask[i] = 1'b1;
                w_enq_k       = w_enq_k + c_CNT_W'(1);
            end else begin
                w_enq_run = 1'b0;
            end
        end
    end

    always_comb begin
        w_deq_run  = 1'b1;
        w_deq_take = '0;
        w_deq_j    = '0;
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            if (w_deq_run && deq_en[i] && w_deq_valid[i] && w_deq_ok) begin
                w_deq_take[i] = 1'b1;
                w_deq_j       = w_deq_j + c_CNT_W'(1);
            end else begin
                w_deq_run = 1'b0;
            end
        end
    end

    // Payload storage carries no reset; pointer reset alone empties the queue.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            if (w_enq_mask[i]) begin
                r_mem[r_tail + c_PTR_W'(i)] <= enq_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= c_PTR_W'(r_head + w_deq_j);
            r_tail  <= c_PTR_W'(r_tail + w_enq_k);
            r_count <= r_count + w_enq_k - w_deq_j;
        end
    end

    generate
        for (genvar gi = 0; gi < DEQ_WIDTH; gi++) begin : g_deq_lane
            logic [c_PTR_W-1:0] w_rd_idx;
            assign w_rd_idx        = r_head + c_PTR_W'(gi);
            assign w_deq_valid[gi] = (r_count > c_CNT_W'(gi));
            assign deq_data[gi*DATA_WIDTH +: DATA_WIDTH] =
                w_deq_valid[gi] ? r_mem[w_rd_idx] : '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multi_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_issue_queue
// Description : Directed self-checking bench for multi_issue_queue (defaults).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_issue_queue;

    localparam int c_DW = 128;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              pause;
    logic [1:0]        enq_valid;
    logic [2*c_DW-1:0] enq_data;
    logic              enq_ready;
    logic [1:0]        deq_valid;
    logic [2*c_DW-1:0] deq_data;
    logic [1:0]        deq_en;
    logic [4:0]        count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [c_DW-1:0] sb [$];
    logic [c_DW-1:0] v_a;
    logic [c_DW-1:0] v_b;

    multi_issue_queue #(
        .DATA_WIDTH (c_DW),
        .DEPTH      (16),
        .ENQ_WIDTH  (2),
        .DEQ_WIDTH  (2)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .pause     (pause),
        .enq_valid (enq_valid),
        .enq_data  (enq_data),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_data  (deq_data),
        .deq_en    (deq_en),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [c_DW-1:0] obs, input logic [c_DW-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_pair(input logic [c_DW-1:0] a, input logic [c_DW-1:0] b);
        enq_data  = {b, a};
        enq_valid = 2'b11;
        step();
        enq_valid = 2'b00;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; pause = 1'b0;
        enq_valid = 2'b00; enq_data = '0; deq_en = 2'b00;
        #1 rst = 1'b0;
        #2;
        check("rst_count", count, 0);
        check("rst_ready", enq_ready, 1);
        check("rst_dvalid", deq_valid, 0);
        repeat (3) step();
        rst = 1'b1;
        step();
        check("post_rst_count", count, 0);
        check("post_rst_ready", enq_ready, 1);

        // basic two-wide enqueue
        put_pair(128'hA, 128'hB);
        check("basic_dvalid", deq_valid, 2'b11);
        check("basic_lane0", deq_data[c_DW-1:0], 128'hA);
        check("basic_lane1", deq_data[2*c_DW-1:c_DW], 128'hB);
        check("basic_count", count, 2);

        deq_en = 2'b11;
        step();
        deq_en = 2'b00;
        check("drain_ab_count", count, 0);

        // fill to full, then a dropped enqueue
        for (int n = 0; n < 8; n++) put_pair(128'h100 + 2*n, 128'h101 + 2*n);
        check("full_count", count, 16);
        check("full_ready", enq_ready, 0);
        put_pair(128'hDEAD, 128'hBEEF);
        check("full_hold_count", count, 16);
        check("full_hold_lane0", deq_data[c_DW-1:0], 128'h100);
        check("full_hold_lane1", deq_data[2*c_DW-1:c_DW], 128'h101);

        deq_en = 2'b11;
        for (int n = 0; n < 8; n++) begin
            check("drain_order", deq_data[c_DW-1:0], 128'h100 + 2*n);
            step();
        end
        step();
        deq_en = 2'b00;
        check("empty_count", count, 0);
        check("empty_dvalid", deq_valid, 0);
        check("empty_lane0_zero", deq_data[c_DW-1:0], 0);
        check("empty_lane1_zero", deq_data[2*c_DW-1:c_DW], 0);

        // partial and non-prefix handling
        put_pair(128'hC1, 128'hC2);
        enq_data  = {128'h0, 128'hC3};
        enq_valid = 2'b01;
        step();
        enq_valid = 2'b00;
        check("xyz_count", count, 3);
        deq_en = 2'b01;
        step();
        check("partial_lane0", deq_data[c_DW-1:0], 128'hC2);
        check("partial_lane1", deq_data[2*c_DW-1:c_DW], 128'hC3);
        check("partial_count", count, 2);
        deq_en = 2'b10;
        step();
        deq_en = 2'b00;
        check("nonprefix_deq_count", count, 2);
        check("nonprefix_deq_lane0", deq_data[c_DW-1:0], 128'hC2);
        enq_data  = {128'hEE, 128'hFF};
        enq_valid = 2'b10;
        step();
        enq_valid = 2'b00;
        check("nonprefix_enq_count", count, 2);
        check("nonprefix_enq_dvalid", deq_valid, 2'b11);

        // streaming 2-in/2-out across the wrap point
        sb.push_back(128'hC2);
        sb.push_back(128'hC3);
        for (int n = 0; n < 15; n++) begin
            check("wrap_lane0", deq_data[c_DW-1:0], sb[0]);
            check("wrap_lane1", deq_data[2*c_DW-1:c_DW], sb[1]);
            v_a = 128'h200 + 2*n;
            v_b = 128'h201 + 2*n;
            enq_data  = {v_b, v_a};
            enq_valid = 2'b11;
            deq_en    = 2'b11;
            sb.push_back(v_a);
            sb.push_back(v_b);
            void'(sb.pop_front());
            void'(sb.pop_front());
            step();
        end
        enq_valid = 2'b00;
        deq_en    = 2'b00;
        check("wrap_count", count, 2);
        check("wrap_tail0", deq_data[c_DW-1:0], 128'h21C);
        check("wrap_tail1", deq_data[2*c_DW-1:c_DW], 128'h21D);

        // enqueue + dequeue at DEPTH-ENQ_WIDTH
        for (int n = 0; n < 6; n++) put_pair(128'h300 + 2*n, 128'h301 + 2*n);
        check("near_full_count", count, 14);
        check("near_full_ready", enq_ready, 1);
        enq_data  = {128'h3F1, 128'h3F0};
        enq_valid = 2'b11;
        deq_en    = 2'b01;
        step();
        enq_valid = 2'b00;
        deq_en    = 2'b00;
        check("simul_count", count, 15);
        check("simul_ready", enq_ready, 0);

        // pause then flush
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush1_count", count, 0);
        put_pair(128'h400, 128'h401);
        put_pair(128'h402, 128'h403);
        pause  = 1'b1;
        deq_en = 2'b11;
        put_pair(128'h404, 128'h405);
        check("pause_count", count, 6);
        check("pause_lane0", deq_data[c_DW-1:0], 128'h400);
        pause     = 1'b0;
        flush     = 1'b1;
        enq_data  = {128'h407, 128'h406};
        enq_valid = 2'b11;
        step();
        flush     = 1'b0;
        enq_valid = 2'b00;
        deq_en    = 2'b00;
        check("flush2_count", count, 0);
        check("flush2_dvalid", deq_valid, 0);
        check("flush2_ready", enq_ready, 1);

        // asynchronous reset between edges
        for (int n = 0; n < 5; n++) put_pair(128'h500 + 2*n, 128'h501 + 2*n);
        check("pre_arst_count", count, 10);
        #3 rst = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_dvalid", deq_valid, 0);
        check("arst_ready", enq_ready, 1);
        check("arst_lane0", deq_data[c_DW-1:0], 0);
        #5 rst = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
